uart_rx_fifo_param: RTL and testbench
=====================================

// Module: uart_rx_fifo_param
// PURPOSE
//  Parametrised UART receiver: 16x oversampled, majority-vote bit sampling, configurable
//  data bits / parity / stop bits, per-word parity and framing error flags, output FIFO
//  with valid/ready handshake and overrun reporting. Next-generation receiver behind Rx_Top.
// PARAMETERS
//  CLK_FREQ    50_000_000  system clock frequency, Hz
//  BAUD        115200      line rate, bit/s
//  DATA_BITS   8           payload bits per frame, legal 5..9
//  PARITY      0           0 = none, 1 = odd, 2 = even
//  STOP_BITS   1           1 or 2
//  FIFO_DEPTH  4           receive FIFO words, power of 2, >= 2
// PORTS
//  Clk          in   1          system clock, rising edge
//  Rst          in   1          asynchronous, active-low reset
//  i_Rx         in   1          serial line, idle high, asynchronous to Clk
//  o_Data       out  DATA_BITS  FIFO head payload, LSB = first bit received
//  o_ParityErr  out  1          parity error flag of head word (0 when PARITY = 0)
//  o_FrameErr   out  1          framing error flag of head word (a stop bit sampled 0)
//  o_Valid      out  1          FIFO not empty; head word presented
//  i_Ready      in   1          consumer accepts head word when o_Valid & i_Ready
//  o_Overrun    out  1          one-cycle pulse: completed word dropped, FIFO full
//  o_Busy       out  1          receiver FSM not in IDLE
// BEHAVIOUR
//  Reset: o_Data=0, flags=0, o_Valid=0, o_Overrun=0, o_Busy=0; FIFO empty; FSM IDLE;
//   synchroniser flops and majority shift register reset to 1 (line idle).
//  i_Rx passes a 2-FF synchroniser before any use. Tick divider DIV =
//   (CLK_FREQ + 8*BAUD)/(16*BAUD) (27 at defaults); counter restarts on start detection.
//  Sample = majority of synchronised i_Rx at ticks 7, 8, 9 of the current bit.
//  FSM: IDLE -> START on falling edge of synchronised line.
//   START: at tick 9, sample 1 -> false start, IDLE; sample 0 -> DATA.
//   DATA: DATA_BITS samples, LSB first -> PARITY if PARITY != 0, else STOP.
//   PARITY: one sample; error if count of ones in data+parity bit mismatches mode.
//   STOP: STOP_BITS samples; any 0 sets frame error. At last stop sample (tick 9):
//    push {data, perr, ferr}, then IDLE so next start edge is accepted mid-stop bit.
//   BREAK: frame error with all data bits 0 -> push word, then hold in BREAK (o_Busy=1)
//    until synchronised line is 1; no further words during the break.
//  Push: word written on cycle of last stop sample; o_Valid high next cycle if FIFO was empty.
//  Pop: on Clk edge where o_Valid & i_Ready; head advances, next word visible next cycle.
//  Simultaneous push and pop when full: pop frees slot, push accepted, no overrun.
//  Push while full without pop: word discarded, FIFO unchanged, o_Overrun=1 one cycle.
//  Pointers are log2(FIFO_DEPTH)+1 bits; full/empty by MSB compare, wrap is natural.
//  o_Data/flags hold the head value while o_Valid=0 (don't-care contents, no X).
//  Reset mid-frame: partial frame discarded, FIFO emptied, FSM IDLE; next frame clean.
// TESTING  (Clk 20 ns, BAUD 115200, bit time 8680 ns, defaults unless noted)
//  1 8N1 bytes 0x3C then 0xE5, i_Ready=1 -> two words 0x3C, 0xE5, all flags 0, no overrun.
//  2 i_Rx low 2000 ns then high -> false start: no word, o_Busy back to 0 within 1 bit time.
//  3 PARITY=2, send 0xA5 with parity bit 1 -> word 0xA5, o_ParityErr=1; with 0 -> flag 0.
//  4 0x55 with stop bit 0 -> o_FrameErr=1; line low 20 bit times -> one word 0x00 with
//    o_FrameErr=1, o_Busy=1 until line high, then next byte 0x12 received correctly.
//  5 i_Ready=0, send 0x01..0x05 -> o_Overrun pulses once on 0x05; then i_Ready=1 pops
//    0x01..0x04 in order, o_Valid drops after 4th pop.
//  6 Rst low for 3 cycles during bit 4 of 0x3C -> all outputs at reset values; following
//    0xC3 received as exactly one word 0xC3, flags 0.

Source files
------------

// File: rtl/uart_rx_fifo_param.sv
`timescale 1ns/1ps
// uart_rx_fifo_param: 16x oversampled UART receiver with majority-vote sampling,
// configurable frame format, per-word parity/framing flags and an output FIFO
// with valid/ready handshake and one-cycle overrun pulse.
module uart_rx_fifo_param #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic                 i_Rx,
    output logic [DATA_BITS-1:0] o_Data,
    output logic                 o_ParityErr,
    output logic                 o_FrameErr,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic                 o_Overrun,
    output logic                 o_Busy
);
    localparam int DIV    = (CLK_FREQ + 8 * BAUD) / (16 * BAUD);
    localparam int DIV_W  = $clog2(DIV + 1);
    localparam int AW     = $clog2(FIFO_DEPTH);
    localparam int WORD_W = DATA_BITS + 2;

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    logic                 rx_meta_q, rx_sync_q, rx_prev_q;
    logic [1:0]           maj_q;
    logic [DIV_W-1:0]     div_cnt_q;
    logic [3:0]           tick_cnt_q, tick_num;
    logic                 tick_en, samp_en, sample;
    state_t               state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 perr_q, perr_d, ferr_q, ferr_d;
    logic                 push;
    logic [WORD_W-1:0]    mem_q [FIFO_DEPTH];
    logic [AW:0]          wr_ptr_q, rd_ptr_q;
    logic                 full, empty, pop, wr_en;
    logic                 overrun_q;
    logic [WORD_W-1:0]    head;

    // Two-flop synchroniser plus previous value for falling-edge detection
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    // Tick index counts 16ths of a bit since the bit began; tick 8 is mid-bit
    assign tick_en  = (state_q != S_IDLE) && (state_q != S_BREAK) &&
                      (div_cnt_q == DIV_W'(DIV - 1));
    assign tick_num = tick_cnt_q + 4'd1;
    assign samp_en  = tick_en && (tick_num == 4'd9);
    assign sample   = maj3(maj_q[1], maj_q[0], rx_sync_q);

    // Baud tick divider, held at zero while idle so it restarts on each start edge
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else if (state_q == S_IDLE || state_q == S_BREAK) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= '0;
        end else if (tick_en) begin
            div_cnt_q  <= '0;
            tick_cnt_q <= tick_num;
        end else begin
            div_cnt_q  <= div_cnt_q + DIV_W'(1);
        end
    end

    // Capture the line at ticks 7 and 8; tick 9 is combined live in the vote
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            maj_q <= 2'b11;
        end else if (tick_en && (tick_num == 4'd7 || tick_num == 4'd8)) begin
            maj_q <= {maj_q[0], rx_sync_q};
        end
    end

    // Receiver state and frame assembly registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q    <= S_IDLE;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Next-state logic: every decision is taken on the tick-9 majority sample
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (rx_prev_q && !rx_sync_q) begin
                    state_d    = S_START;
                    bit_cnt_d  = '0;
                    stop_cnt_d = 1'b0;
                    perr_d     = 1'b0;
                    ferr_d     = 1'b0;
                end
            end
            S_START: begin
                if (samp_en) state_d = sample ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (samp_en) begin
                    shift_d   = {sample, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(DATA_BITS - 1))
                        state_d = (PARITY != 0) ? S_PARITY : S_STOP;
                end
            end
            S_PARITY: begin
                if (samp_en) begin
                    // Odd mode expects an odd total of ones, even mode an even total
                    perr_d  = (^shift_q) ^ sample ^ (PARITY == 1);
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (samp_en) begin
                    ferr_d = ferr_q | ~sample;
                    if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
                        push    = 1'b1;
                        state_d = (ferr_d && shift_q == '0) ? S_BREAK : S_IDLE;
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
            end
            S_BREAK: begin
                if (rx_sync_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign pop   = !empty && i_Ready;
    assign wr_en = push && (!full || pop);

    // FIFO storage; cleared on reset so the head never shows X
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {perr_d, ferr_d, shift_q};
        end
    end

    // FIFO pointers and overrun pulse
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
            overrun_q <= push && full && !pop;
        end
    end

    assign head        = mem_q[rd_ptr_q[AW-1:0]];
    assign o_Data      = head[DATA_BITS-1:0];
    assign o_FrameErr  = head[DATA_BITS];
    assign o_ParityErr = head[DATA_BITS+1];
    assign o_Valid     = !empty;
    assign o_Overrun   = overrun_q;
    assign o_Busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx_fifo_param.sv
`timescale 1ns/1ps
// Directed bench for uart_rx_fifo_param: default 8N1 instance plus an even-parity instance.
module tb_uart_rx_fifo_param;
    localparam int BIT = 8680;

    logic       Clk = 1'b0;
    logic       Rst = 1'b0;
    logic       rx = 1'b1, rx_p = 1'b1;
    logic       Ready = 1'b0, ReadyP = 1'b1;
    logic [7:0] o_Data, o_Data_p;
    logic       o_ParityErr, o_FrameErr, o_Valid, o_Overrun, o_Busy;
    logic       o_ParityErr_p, o_FrameErr_p, o_Valid_p, o_Overrun_p, o_Busy_p;

    int checks = 0;
    int errors = 0;
    int ovr = 0;
    logic [9:0] q[$];
    logic [9:0] qp[$];

    always #10 Clk = ~Clk;

    uart_rx_fifo_param dut (
        .Clk(Clk), .Rst(Rst), .i_Rx(rx), .o_Data(o_Data), .o_ParityErr(o_ParityErr),
        .o_FrameErr(o_FrameErr), .o_Valid(o_Valid), .i_Ready(Ready),
        .o_Overrun(o_Overrun), .o_Busy(o_Busy)
    );

    uart_rx_fifo_param #(.PARITY(2)) dut_p (
        .Clk(Clk), .Rst(Rst), .i_Rx(rx_p), .o_Data(o_Data_p), .o_ParityErr(o_ParityErr_p),
        .o_FrameErr(o_FrameErr_p), .o_Valid(o_Valid_p), .i_Ready(ReadyP),
        .o_Overrun(o_Overrun_p), .o_Busy(o_Busy_p)
    );

    // Record every accepted word as {perr, ferr, data} and count overrun cycles
    always @(posedge Clk) begin
        if (o_Valid && Ready)    q.push_back({o_ParityErr, o_FrameErr, o_Data});
        if (o_Valid_p && ReadyP) qp.push_back({o_ParityErr_p, o_FrameErr_p, o_Data_p});
        if (o_Overrun) ovr = ovr + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic line(input bit sel, input logic v);
        if (sel) rx_p = v;
        else     rx = v;
    endtask

    task automatic send_bits(input bit sel, input logic [15:0] b, input int n);
        for (int i = 0; i < n; i++) begin
            line(sel, b[i]);
            #(BIT);
        end
        line(sel, 1'b1);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_bits(1'b0, {6'b0, 1'b1, d, 1'b0}, 10);
    endtask

    initial begin
        int base, bp, ob;
        // Reset state
        repeat (3) @(negedge Clk);
        chk("reset_valid", o_Valid, 0);
        chk("reset_busy", o_Busy, 0);
        chk("reset_data", o_Data, 0);
        chk("reset_flags", {o_ParityErr, o_FrameErr, o_Overrun}, 0);
        Rst = 1'b1;
        Ready = 1'b1;
        repeat (5) @(negedge Clk);

        // Two 8N1 bytes with consumer always ready
        base = q.size(); ob = ovr;
        send_byte(8'h3C);
        send_byte(8'hE5);
        #(BIT);
        chk("t1_count", q.size() - base, 2);
        chk("t1_word0", q[base], 10'h03C);
        chk("t1_word1", q[base+1], 10'h0E5);
        chk("t1_overrun", ovr - ob, 0);

        // Short low glitch is a false start
        base = q.size();
        line(1'b0, 1'b0);
        #2000;
        chk("t2_busy_hi", o_Busy, 1);
        line(1'b0, 1'b1);
        #(BIT);
        chk("t2_busy_lo", o_Busy, 0);
        chk("t2_no_word", q.size() - base, 0);

        // Even parity: 0xA5 has four ones, so parity bit 1 is an error
        bp = qp.size();
        send_bits(1'b1, {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11);
        send_bits(1'b1, {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11);
        #(BIT);
        chk("t3_count", qp.size() - bp, 2);
        chk("t3_perr1", qp[bp], 10'h2A5);
        chk("t3_perr0", qp[bp+1], 10'h0A5);

        // Framing error, then a long break, then a clean byte
        base = q.size();
        send_bits(1'b0, {6'b0, 1'b0, 8'h55, 1'b0}, 10);
        #(BIT);
        chk("t4_ferr_word", q[base], 10'h155);
        line(1'b0, 1'b0);
        #(20 * BIT);
        chk("t4_break_busy", o_Busy, 1);
        chk("t4_break_count", q.size() - base, 2);
        chk("t4_break_word", q[base+1], 10'h100);
        line(1'b0, 1'b1);
        #200;
        chk("t4_break_end", o_Busy, 0);
        send_byte(8'h12);
        #(BIT);
        chk("t4_after_count", q.size() - base, 3);
        chk("t4_after_word", q[base+2], 10'h012);

        // Fill the FIFO with the consumer stalled; fifth byte overruns
        Ready = 1'b0;
        base = q.size(); ob = ovr;
        for (int d = 1; d <= 5; d++) send_byte(8'(d));
        #(BIT);
        chk("t5_overrun", ovr - ob, 1);
        chk("t5_valid_full", o_Valid, 1);
        chk("t5_head", o_Data, 8'h01);
        Ready = 1'b1;
        repeat (8) @(negedge Clk);
        chk("t5_pop_count", q.size() - base, 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t5_pop%0d", i), q[base+i], 32'(i + 1));
        chk("t5_valid_empty", o_Valid, 0);

        // Reset in the middle of a frame with a word waiting in the FIFO
        Ready = 1'b0;
        send_byte(8'h7E);
        chk("t6_pre_valid", o_Valid, 1);
        send_bits(1'b0, {6'b0, 1'b1, 8'h3C, 1'b0}, 5);
        #4000;
        chk("t6_pre_busy", o_Busy, 1);
        Rst = 1'b0;
        repeat (3) @(negedge Clk);
        chk("t6_rst_valid", o_Valid, 0);
        chk("t6_rst_busy", o_Busy, 0);
        chk("t6_rst_data", o_Data, 0);
        chk("t6_rst_flags", {o_ParityErr, o_FrameErr, o_Overrun}, 0);
        Rst = 1'b1;
        #(2 * BIT);
        chk("t6_idle_busy", o_Busy, 0);
        Ready = 1'b1;
        base = q.size();
        send_byte(8'hC3);
        #(BIT);
        chk("t6_count", q.size() - base, 1);
        chk("t6_word", q[base], 10'h0C3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
